// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button synchronisers with press detection, IDLE/RUN/LAP/STOP FSM, prescaled tick counter.
// Build with STOPWATCH_LAP_EN defined to include the LAP state and lap-freeze output; otherwise pause is tied low.
module stopwatch_ctrl #(
  parameter int DIV       = 50000,
  parameter int MAX_COUNT = 1999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        lap_btn,
  output logic [10:0] count,
  output logic        pause,
  output logic        running,
  output logic        wrap
);

`ifdef STOPWATCH_LAP_EN
  typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
`endif

  localparam logic [15:0] PRESC_LAST = 16'(DIV - 1);
  localparam logic [10:0] COUNT_LAST = 11'(MAX_COUNT);

  state_t      state, state_nxt;
  logic        start_p0, start_p1, start_p2;
  logic        lap_p0, lap_p1, lap_p2;
  logic [1:0]  arm_cnt;
  logic        armed;
  logic        start_pls, lap_pls;
  logic        clear;
  logic        running_nxt;
  logic        in_run;
  logic        tick;
  logic [15:0] presc;
`ifdef STOPWATCH_LAP_EN
  logic        pause_nxt;
`endif

  function automatic logic [10:0] count_inc(input logic [10:0] c);
    return (c == COUNT_LAST) ? 11'd0 : c + 11'd1;
  endfunction

  // p0/p1 synchronise, p2 is the delayed copy for rising-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_p0 <= 1'b0;
      start_p1 <= 1'b0;
      start_p2 <= 1'b0;
      lap_p0   <= 1'b0;
      lap_p1   <= 1'b0;
      lap_p2   <= 1'b0;
      arm_cnt  <= 2'd0;
    end else begin
      start_p0 <= start_btn;
      start_p1 <= start_p0;
      start_p2 <= start_p1;
      lap_p0   <= lap_btn;
      lap_p1   <= lap_p0;
      lap_p2   <= lap_p1;
      if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
    end
  end

  // A button already high at reset release fills the chain before arming, so it never pulses.
  assign armed     = (arm_cnt == 2'd3);
  assign start_pls = armed & start_p1 & ~start_p2;
  assign lap_pls   = armed & lap_p1 & ~lap_p2;

  // FSM stage: state register with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= running_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    case (state)
      IDLE: if (start_pls) state_nxt = RUN;
`ifdef STOPWATCH_LAP_EN
      RUN: begin
        if (start_pls)    state_nxt = STOP;
        else if (lap_pls) state_nxt = LAP;
      end
      LAP: begin
        if (start_pls)    state_nxt = STOP;
        else if (lap_pls) state_nxt = RUN;
      end
`else
      RUN: if (start_pls) state_nxt = STOP;
`endif
      STOP: begin
        if (start_pls) begin
          state_nxt = RUN;
        end else if (lap_pls) begin
          state_nxt = IDLE;
          clear     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    running_nxt = 1'b0;
`ifdef STOPWATCH_LAP_EN
    pause_nxt   = 1'b0;
`endif
    case (state_nxt)
      RUN: running_nxt = 1'b1;
`ifdef STOPWATCH_LAP_EN
      LAP: begin
        running_nxt = 1'b1;
        pause_nxt   = 1'b1;
      end
`endif
      default: running_nxt = 1'b0;
    endcase
  end

`ifdef STOPWATCH_LAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pause <= 1'b0;
    else      pause <= pause_nxt;
  end

  assign in_run = (state == RUN) || (state == LAP);
`else
  assign pause  = 1'b0;
  assign in_run = (state == RUN);
`endif

  // Tick/count stage: tick follows the current state, so a tick on a stop edge still lands
  assign tick = in_run && (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= 16'd0;
      count <= 11'd0;
      wrap  <= 1'b0;
    end else begin
      wrap <= tick && (count == COUNT_LAST);
      if (clear) begin
        presc <= 16'd0;
        count <= 11'd0;
      end else if (in_run) begin
        presc <= tick ? 16'd0 : presc + 16'd1;
        if (tick) count <= count_inc(count);
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: elapsed-cycle model checked every cycle plus hand-computed checkpoints.
module tb_stopwatch_ctrl;
  localparam int DIV       = 4;
  localparam int MAX_COUNT = 9;
`ifdef STOPWATCH_LAP_EN
  localparam int LAP_EN = 1;
`else
  localparam int LAP_EN = 0;
`endif
  localparam int S_IDLE = 0, S_RUN = 1, S_LAP = 2, S_STOP = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_btn = 1'b0;
  logic        lap_btn = 1'b0;
  logic [10:0] count;
  logic        pause, running, wrap;

  stopwatch_ctrl #(.DIV(DIV), .MAX_COUNT(MAX_COUNT)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .lap_btn(lap_btn),
    .count(count), .pause(pause), .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int active = 0;
  int m_state = S_IDLE;
  int wrap_cnt = 0;
  bit m_wrap = 1'b0;
  bit m_was, m_st, m_lp;
  int st_q[$];
  int lp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: elapsed time is the number of cycles spent running; count and wrap follow from it.
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      m_state = S_IDLE;
      active  = 0;
      m_wrap  = 1'b0;
      st_q.delete();
      lp_q.delete();
    end else begin
      m_st = 1'b0;
      m_lp = 1'b0;
      while (st_q.size() > 0 && st_q[0] <= cyc) begin
        if (st_q[0] == cyc) m_st = 1'b1;
        void'(st_q.pop_front());
      end
      while (lp_q.size() > 0 && lp_q[0] <= cyc) begin
        if (lp_q[0] == cyc) m_lp = 1'b1;
        void'(lp_q.pop_front());
      end
      m_was = (m_state == S_RUN) || (m_state == S_LAP);
      if (m_was) active++;
      m_wrap = m_was && (active % DIV == 0) && ((active / DIV) % (MAX_COUNT + 1) == 0);
      case (m_state)
        S_IDLE: if (m_st) m_state = S_RUN;
        S_RUN: begin
          if (m_st) m_state = S_STOP;
          else if (m_lp && LAP_EN == 1) m_state = S_LAP;
        end
        S_LAP: begin
          if (m_st) m_state = S_STOP;
          else if (m_lp) m_state = S_RUN;
        end
        default: begin
          if (m_st) m_state = S_RUN;
          else if (m_lp) begin
            m_state = S_IDLE;
            active  = 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("count", int'(count), (active / DIV) % (MAX_COUNT + 1));
    check("running", int'(running), int'((m_state == S_RUN) || (m_state == S_LAP)));
    check("pause", int'(pause), int'(m_state == S_LAP));
    check("wrap", int'(wrap), int'(m_wrap));
    if (wrap) wrap_cnt++;
  end

  task automatic goto_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press at the current negedge; the model expects the effect on the third rising edge.
  task automatic push(input bit s, input bit l, input int hold);
    if (s) begin start_btn = 1'b1; st_q.push_back(cyc + 3); end
    if (l) begin lap_btn = 1'b1; lp_q.push_back(cyc + 3); end
    repeat (hold) @(negedge clk);
    start_btn = 1'b0;
    lap_btn   = 1'b0;
  endtask

  int e, s, r, l;

  initial begin
    gap(3);
    check("rst_count", int'(count), 0);
    check("rst_running", int'(running), 0);
    check("rst_pause", int'(pause), 0);
    check("rst_wrap", int'(wrap), 0);
    #2 rst = 1'b1;
    gap(6);

    // start, then 40 running cycles: ten ticks, one wrap back to 0
    wrap_cnt = 0;
    start_btn = 1'b1;
    e = cyc + 3;
    st_q.push_back(e);
    goto_cyc(e - 1);
    check("run_before_3rd_edge", int'(running), 0);
    goto_cyc(e);
    check("run_on_3rd_edge", int'(running), 1);
    start_btn = 1'b0;
    goto_cyc(e + 41);
    check("wrapped_count", int'(count), 0);
    check("wrap_pulses", wrap_cnt, 1);
    check("no_pause_in_run", int'(pause), 0);

    // stop and clear back to IDLE
    push(1'b1, 1'b0, 2);
    gap(4);
    push(1'b0, 1'b1, 2);
    gap(5);
    check("idle_count", int'(count), 0);

    // stop with prescaler at 2 and count 5, freeze 20 clk, resume
    e = cyc + 3;
    push(1'b1, 1'b0, 2);
    goto_cyc(e + 20);
    s = cyc + 3;
    push(1'b1, 1'b0, 2);
    goto_cyc(s);
    check("stop_count", int'(count), 5);
    check("stop_running", int'(running), 0);
    goto_cyc(s + 20);
    check("frozen_count", int'(count), 5);
    r = cyc + 3;
    push(1'b1, 1'b0, 2);
    goto_cyc(r);
    check("resume_count", int'(count), 5);
    goto_cyc(r + 1);
    check("first_tick_after_resume", int'(count), 6);

    // stop at count 5, lap clears to IDLE, second lap ignored
    goto_cyc(r + 35);
    push(1'b1, 1'b0, 2);
    goto_cyc(r + 38);
    check("stop2_count", int'(count), 5);
    goto_cyc(r + 40);
    l = cyc + 3;
    push(1'b0, 1'b1, 2);
    goto_cyc(l);
    check("clear_count", int'(count), 0);
    check("clear_running", int'(running), 0);
    gap(4);
    push(1'b0, 1'b1, 2);
    gap(6);
    check("second_lap_count", int'(count), 0);
    check("second_lap_running", int'(running), 0);

    // start and lap together from RUN, held 50 clk
    e = cyc + 3;
    push(1'b1, 1'b0, 2);
    goto_cyc(e + 6);
    start_btn = 1'b1;
    lap_btn   = 1'b1;
    st_q.push_back(cyc + 3);
    lp_q.push_back(cyc + 3);
    goto_cyc(e + 9);
    check("both_running", int'(running), 0);
    check("both_pause", int'(pause), 0);
    goto_cyc(e + 56);
    check("held_single_transition", int'(running), 0);
    check("held_count", int'(count), 2);
    start_btn = 1'b0;
    lap_btn   = 1'b0;
    gap(5);
    push(1'b0, 1'b1, 2);
    gap(5);

    // lap from RUN at count 3, lap again 12 clk later, then reset mid-count
    e = cyc + 3;
    push(1'b1, 1'b0, 2);
    goto_cyc(e + 10);
    push(1'b0, 1'b1, 2);
    goto_cyc(e + 13);
    check("lap_pause", int'(pause), LAP_EN);
    check("lap_running", int'(running), 1);
    check("lap_count", int'(count), 3);
    goto_cyc(e + 22);
    push(1'b0, 1'b1, 2);
    goto_cyc(e + 24);
    check("lap_count_6", int'(count), 6);
    check("lap_pause_6", int'(pause), LAP_EN);
    goto_cyc(e + 25);
    check("unlap_pause", int'(pause), 0);
    check("unlap_running", int'(running), 1);
    goto_cyc(e + 31);
    check("pre_reset_count", int'(count), 7);
    #2 rst = 1'b0;
    #1;
    check("async_rst_count", int'(count), 0);
    check("async_rst_running", int'(running), 0);
    check("async_rst_pause", int'(pause), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    gap(5);
    check("post_reset_count", int'(count), 0);

    // button held across reset release must not start
    start_btn = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    gap(10);
    check("held_at_release", int'(running), 0);
    start_btn = 1'b0;
    gap(5);

    // lap, stop from lap (or run), clear
    push(1'b1, 1'b0, 2);
    gap(6);
    push(1'b0, 1'b1, 2);
    gap(6);
    check("lap2_pause", int'(pause), LAP_EN);
    push(1'b1, 1'b0, 2);
    gap(6);
    check("lap_stop_pause", int'(pause), 0);
    check("lap_stop_running", int'(running), 0);
    push(1'b0, 1'b1, 2);
    gap(6);
    check("final_count", int'(count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 50000: clk cycles per count tick, range 2..65535.
REQ-002 SHALL have parameter MAX_COUNT, default 1999: last count value before wrap, range 1..2047.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset; clk is the only clock.
REQ-005 SHALL have port start_btn  input  1  raw, asynchronous start/stop button, active-high.
REQ-006 SHALL have port lap_btn  input  1  raw, asynchronous lap/clear button, active-high.
REQ-007 SHALL have port count  output  11  current elapsed-tick value, drives the display holder's data input.
REQ-008 SHALL have port pause  output  1  freeze request to the display holder, high only in LAP.
REQ-009 SHALL have port running  output  1  high in RUN and LAP.
REQ-010 SHALL have port wrap  output  1  one-cycle pulse when count wraps MAX_COUNT->0.

Function
REQ-011 SHALL synchronise each button through two flops, then detect rising edges against a third registered copy, giving a one-cycle press pulse.
REQ-012 SHALL apply a state change on the 3rd rising clk edge after a button goes high, with the input stable before the 1st edge.
REQ-013 SHALL produce one pulse per press however long the button is held; a new pulse needs the synchronised level to go low and then high again.
REQ-014 SHALL implement the FSM states IDLE, RUN, LAP and STOP; encoding is free.
REQ-015 SHALL make these FSM transitions:
- IDLE, start -> RUN
- RUN, start -> STOP
- RUN, lap -> LAP
- LAP, lap -> RUN
- LAP, start -> STOP
- STOP, start -> RUN
- STOP, lap -> IDLE
- any other pulse in a state is ignored
REQ-016 SHALL give start priority when start and lap pulses occur in the same cycle; the lap pulse is discarded.
REQ-017 SHALL run a 16-bit prescaler 0..DIV-1 only in RUN and LAP; it holds its value in STOP and is 0 in IDLE.
REQ-018 SHALL generate a tick in the cycle the prescaler equals DIV-1, and wrap the prescaler to 0 on that edge.
REQ-019 SHALL increment count by 1 on each tick; at MAX_COUNT a tick loads 0 and asserts wrap for exactly that following cycle.
REQ-020 SHALL keep counting in LAP with pause=1; pause SHALL go high on the edge entering LAP and low on the edge leaving it.
REQ-021 SHALL resume from STOP -> RUN with count and prescaler unchanged, with no lost or extra tick.
REQ-022 SHALL clear count and prescaler to 0 on the same edge as the STOP -> IDLE transition.
REQ-023 SHALL let a tick coincident with a RUN -> STOP or LAP -> STOP transition still update count; nothing advances afterwards.
REQ-024 SHALL drive all outputs from registers, with no combinational path from buttons.

Reset
REQ-025 SHALL, while rst=0, immediately force state=IDLE, count=0, prescaler=0, pause=0, running=0, wrap=0 and all sync/edge flops=0.
REQ-026 SHALL abandon a reset asserted mid-count without completing a pending tick or wrap pulse.
REQ-027 SHALL not generate a press pulse on reset release from a button already held high; a pulse needs a low-to-high after release.

Configuration
REQ-028 SHALL, with macro STOPWATCH_LAP_EN defined, implement LAP and the lap-button function as specified above.
REQ-029 SHALL, without STOPWATCH_LAP_EN:
- have no LAP state
- tie pause to constant 0
- ignore lap pulses in RUN
- still apply STOP, lap -> IDLE clear
- keep port list unchanged

Verification (DIV=4, MAX_COUNT=9, macro defined unless noted)
REQ-030 SHALL cover: reset, start pulse, run 40 clk -> running=1 on 3rd edge after press; count=10 ticks' worth wrapped, i.e. count=0 with one wrap pulse; pause=0.
REQ-031 SHALL cover: RUN at count=3, lap press, 12 clk, lap press -> pause=1 for the LAP interval; count reaches 6 while pause=1; pause=0 after the 2nd press.
REQ-032 SHALL cover: RUN, start at prescaler=2, idle 20 clk, start -> count frozen for 20 clk; the next tick arrives 1 clk after resume effect.
REQ-033 SHALL cover: STOP at count=5, lap press -> IDLE, count=0, prescaler=0; a second lap press changes nothing.
REQ-034 SHALL cover: start and lap pressed in the same cycle from RUN -> STOP, pause stays 0; the button held 50 clk gives a single transition.
REQ-035 SHALL cover: rst low for 1 clk mid-RUN at count=7 -> all outputs 0 at once; without the macro, lap in RUN -> pause stays 0, count continues.
